// File: rtl/mppt_pwm_gen.sv
// PWM generator for the MPPT buck stage: free-running period counter, shadowed
// duty register, dead-band gate FSM and a divided sample strobe for the MPPT loop.
//
//  state  | meaning
//  OFF    | disabled, both gates low
//  HI     | high-side gate on
//  LO     | low-side gate on
//  DEAD   | both gates low, dead counter running
module mppt_pwm_gen #(
   parameter logic [15:0] PERIOD     = 16'h3FFF,
   parameter logic [7:0]  DEAD_TIME  = 8'd16,
   parameter logic [7:0]  SAMPLE_DIV = 8'd4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [15:0] duty_in,
   input  logic        duty_valid,
   output logic        pwm_hi,
   output logic        pwm_lo,
   output logic [15:0] duty_active,
   output logic        period_start,
   output logic        sample_req
);

   typedef enum logic [1:0] {
      S_OFF  = 2'b00,
      S_HI   = 2'b01,
      S_LO   = 2'b10,
      S_DEAD = 2'b11
   } state_t;

   localparam logic [15:0] HALF = PERIOD >> 1;

   state_t      state;
   state_t      state_nxt;
   logic [7:0]  dead_cnt;
   logic [7:0]  dead_nxt;
   logic        hi_nxt;
   logic        lo_nxt;
   logic [15:0] cnt;
   logic [15:0] shadow;
   logic [7:0]  div;
   logic        run;
   logic        wrap;
   logic        load_duty;
   logic        raw;

   // run is enable delayed by one edge; its rising edge marks the first period
   assign wrap      = run && (cnt == PERIOD);
   assign load_duty = enable && (!run || wrap);
   assign raw       = (duty_active >= PERIOD) || (cnt < duty_active);

   assign period_start = enable && run && (cnt == 16'd0);
   assign sample_req   = enable && run && (div == 8'd0) && (cnt == HALF);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         run         <= 1'b0;
         cnt         <= 16'd0;
         shadow      <= 16'h2000;
         duty_active <= 16'h2000;
         div         <= 8'd0;
      end else begin
         run <= enable;

         if (!enable || wrap) begin
            cnt <= 16'd0;
         end else if (run) begin
            cnt <= cnt + 16'd1;
         end

         if (duty_valid) begin
            shadow <= (duty_in > PERIOD) ? PERIOD : duty_in;
         end

         // shadow reset value can exceed a small PERIOD, so clamp again here
         if (load_duty) begin
            duty_active <= (shadow > PERIOD) ? PERIOD : shadow;
         end

         if (!enable) begin
            div <= 8'd0;
         end else if (wrap) begin
            div <= (div >= SAMPLE_DIV - 8'd1) ? 8'd0 : div + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= S_OFF;
         dead_cnt <= 8'd0;
         pwm_hi   <= 1'b0;
         pwm_lo   <= 1'b0;
      end else begin
         state    <= state_nxt;
         dead_cnt <= dead_nxt;
         pwm_hi   <= hi_nxt;
         pwm_lo   <= lo_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      dead_nxt  = dead_cnt;
      if (!enable) begin
         state_nxt = S_OFF;
         dead_nxt  = 8'd0;
      end else begin
         case (state)
            S_OFF: begin
               state_nxt = S_DEAD;
               dead_nxt  = DEAD_TIME;
            end
            S_HI: begin
               if (!raw) begin
                  state_nxt = S_DEAD;
                  dead_nxt  = DEAD_TIME;
               end
            end
            S_LO: begin
               if (raw) begin
                  state_nxt = S_DEAD;
                  dead_nxt  = DEAD_TIME;
               end
            end
            S_DEAD: begin
               // expiry picks the side from raw at that moment; raw edges inside
               // the band do not reload the counter
               if (dead_cnt <= 8'd1) begin
                  state_nxt = raw ? S_HI : S_LO;
                  dead_nxt  = 8'd0;
               end else begin
                  dead_nxt = dead_cnt - 8'd1;
               end
            end
            default: begin
               state_nxt = S_OFF;
               dead_nxt  = 8'd0;
            end
         endcase
      end
   end

   always_comb begin
      hi_nxt = (state_nxt == S_HI);
      lo_nxt = (state_nxt == S_LO);
   end

endmodule

// File: tb/tb_mppt_pwm_gen.sv
// Scoreboard bench for mppt_pwm_gen: stimulus pushes per-period expectations,
// a monitor measures each period between period_start pulses and compares.
module tb_mppt_pwm_gen;

   logic        clk;
   logic        reset;
   logic        enable;
   logic [15:0] duty_in;
   logic        duty_valid;
   logic        pwm_hi, pwm_lo, period_start, sample_req;
   logic [15:0] duty_active;
   logic        pwm_hi3, pwm_lo3, period_start3, sample_req3;
   logic [15:0] duty_active3;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string name;
      int    d;
      int    hi;
      int    lo;
      int    samp;
      int    soff;
      int    s3;
   } exp_t;

   exp_t sb[$];

   bit m_open = 1'b0;
   int m_d, m_d3, m_hi, m_lo, m_hi3, m_lo3, m_samp, m_soff, m_s3, m_ps3, m_off;

   mppt_pwm_gen #(.PERIOD(16'd15), .DEAD_TIME(8'd2), .SAMPLE_DIV(8'd1)) u_dut (
      .clk(clk), .reset(reset), .enable(enable), .duty_in(duty_in),
      .duty_valid(duty_valid), .pwm_hi(pwm_hi), .pwm_lo(pwm_lo),
      .duty_active(duty_active), .period_start(period_start), .sample_req(sample_req)
   );

   mppt_pwm_gen #(.PERIOD(16'd15), .DEAD_TIME(8'd2), .SAMPLE_DIV(8'd3)) u_dut3 (
      .clk(clk), .reset(reset), .enable(enable), .duty_in(duty_in),
      .duty_valid(duty_valid), .pwm_hi(pwm_hi3), .pwm_lo(pwm_lo3),
      .duty_active(duty_active3), .period_start(period_start3), .sample_req(sample_req3)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic cmp(input string n, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", n, act, exp);
      end
   endtask

   task automatic push(input string n, input int d, input int hi, input int lo,
                       input int samp, input int soff, input int s3);
      exp_t e;
      e.name = n; e.d = d; e.hi = hi; e.lo = lo;
      e.samp = samp; e.soff = soff; e.s3 = s3;
      sb.push_back(e);
   endtask

   task automatic close_rec();
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected_period: got a period record, expected none");
      end else begin
         e = sb.pop_front();
         cmp({e.name, ".duty_active"}, m_d, e.d);
         cmp({e.name, ".duty_active_div3"}, m_d3, e.d);
         cmp({e.name, ".hi_cycles"}, m_hi, e.hi);
         cmp({e.name, ".lo_cycles"}, m_lo, e.lo);
         cmp({e.name, ".hi_cycles_div3"}, m_hi3, e.hi);
         cmp({e.name, ".lo_cycles_div3"}, m_lo3, e.lo);
         cmp({e.name, ".sample_pulses"}, m_samp, e.samp);
         cmp({e.name, ".sample_offset"}, m_soff, e.soff);
         cmp({e.name, ".sample_pulses_div3"}, m_s3, e.s3);
         cmp({e.name, ".period_start_div3"}, m_ps3, 1);
      end
   endtask

   task automatic monitor();
      forever begin
         @(negedge clk);
         cmp("overlap", int'(pwm_hi && pwm_lo), 0);
         cmp("overlap_div3", int'(pwm_hi3 && pwm_lo3), 0);
         if (!reset || !enable) begin
            if (m_open) close_rec();
            m_open = 1'b0;
         end else begin
            if (period_start) begin
               if (m_open) close_rec();
               m_open = 1'b1;
               m_d = int'(duty_active); m_d3 = int'(duty_active3);
               m_hi = 0; m_lo = 0; m_hi3 = 0; m_lo3 = 0;
               m_samp = 0; m_soff = -1; m_s3 = 0; m_ps3 = 0; m_off = 0;
            end
            if (m_open) begin
               if (pwm_hi) m_hi++;
               if (pwm_lo) m_lo++;
               if (pwm_hi3) m_hi3++;
               if (pwm_lo3) m_lo3++;
               if (sample_req) begin
                  m_samp++;
                  m_soff = m_off;
               end
               if (sample_req3) m_s3++;
               if (period_start3) m_ps3++;
               m_off++;
            end
         end
      end
   endtask

   task automatic step(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   task automatic strobe(input logic [15:0] v);
      duty_in    = v;
      duty_valid = 1'b1;
      @(posedge clk);
      #1;
      duty_valid = 1'b0;
   endtask

   task automatic wait_ps(input string n);
      int k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!period_start && k < 40);
      cmp({n, ".period_start_seen"}, int'(period_start), 1);
   endtask

   initial begin
      reset      = 1'b0;
      enable     = 1'b0;
      duty_in    = 16'd0;
      duty_valid = 1'b0;
      fork
         monitor();
         begin
            #100000;
            $display("FAIL watchdog: got timeout, expected finish");
            $fatal(1, "watchdog");
         end
      join_none

      step(3);
      cmp("rst.pwm_hi", int'(pwm_hi), 0);
      cmp("rst.pwm_lo", int'(pwm_lo), 0);
      cmp("rst.duty_active", int'(duty_active), 16'h2000);
      cmp("rst.period_start", int'(period_start), 0);
      cmp("rst.sample_req", int'(sample_req), 0);
      reset = 1'b1;
      step(1);
      strobe(16'd8);
      cmp("disabled.duty_active_held", int'(duty_active), 16'h2000);
      cmp("disabled.pwm_hi", int'(pwm_hi), 0);

      push("pi0", 8, 7, 5, 1, 7, 1);
      push("pi1", 8, 6, 6, 1, 7, 0);
      push("pi2", 8, 6, 6, 1, 7, 0);
      push("pi3", 8, 6, 6, 1, 7, 1);
      enable = 1'b1;
      wait_ps("pi0");
      cmp("first.dead_hi", int'(pwm_hi), 0);
      cmp("first.dead_lo", int'(pwm_lo), 0);
      wait_ps("pi1");
      wait_ps("pi2");
      wait_ps("pi3");

      push("pi4", 4, 2, 10, 1, 7, 0);
      push("pi5", 4, 2, 10, 1, 7, 0);
      step(5);
      strobe(16'd4);
      cmp("mid_period.duty_held", int'(duty_active), 8);
      wait_ps("pi4");
      cmp("wrap.duty_loaded", int'(duty_active), 4);
      wait_ps("pi5");

      push("pi6", 15, 13, 1, 1, 7, 1);
      push("pi7", 15, 16, 0, 1, 7, 0);
      step(2);
      strobe(16'h3FFF);
      cmp("clamp.duty_held", int'(duty_active), 4);
      wait_ps("pi6");
      cmp("clamp.duty_active", int'(duty_active), 15);
      wait_ps("pi7");

      push("pi8", 2, 3, 11, 1, 7, 0);
      push("pi9", 2, 0, 14, 1, 7, 1);
      push("pi10", 2, 0, 14, 1, 7, 0);
      step(2);
      strobe(16'd2);
      wait_ps("pi8");
      wait_ps("pi9");
      wait_ps("pi10");

      push("pi11", 13, 11, 1, 1, 7, 0);
      push("pi12", 13, 7, 1, 1, 7, 1);
      step(2);
      strobe(16'd13);
      wait_ps("pi11");
      wait_ps("pi12");
      step(10);
      cmp("pre_disable.pwm_hi", int'(pwm_hi), 1);
      enable = 1'b0;
      step(1);
      cmp("disable.pwm_hi", int'(pwm_hi), 0);
      cmp("disable.pwm_lo", int'(pwm_lo), 0);
      cmp("disable.period_start", int'(period_start), 0);
      cmp("disable.sample_req", int'(sample_req), 0);
      cmp("disable.duty_retained", int'(duty_active), 13);
      step(3);
      cmp("disabled.pwm_lo", int'(pwm_lo), 0);

      push("q0", 13, 12, 0, 1, 7, 1);
      push("q1", 13, 11, 1, 1, 7, 0);
      push("q2", 13, 0, 1, 0, -1, 0);
      enable = 1'b1;
      wait_ps("q0");
      cmp("reenable.dead_hi", int'(pwm_hi), 0);
      cmp("reenable.dead_lo", int'(pwm_lo), 0);
      wait_ps("q1");
      wait_ps("q2");
      step(3);
      cmp("pre_reset.pwm_hi", int'(pwm_hi), 1);
      reset = 1'b0;
      #1;
      cmp("async_rst.pwm_hi", int'(pwm_hi), 0);
      cmp("async_rst.pwm_lo", int'(pwm_lo), 0);
      cmp("async_rst.duty_active", int'(duty_active), 16'h2000);
      cmp("async_rst.period_start", int'(period_start), 0);
      step(1);
      reset = 1'b1;

      push("r0", 15, 14, 0, 1, 7, 1);
      push("r1", 15, 16, 0, 1, 7, 0);
      push("r2", 15, 16, 0, 1, 7, 0);
      push("r3", 0, 1, 13, 1, 7, 1);
      push("r4", 0, 0, 16, 1, 7, 0);
      push("r5", 0, 0, 1, 0, -1, 0);
      wait_ps("r0");
      wait_ps("r1");
      step(15);
      strobe(16'd0);
      wait_ps("r2");
      cmp("wrap_strobe.duty_deferred", int'(duty_active), 15);
      wait_ps("r3");
      cmp("wrap_strobe.duty_applied", int'(duty_active), 0);
      wait_ps("r4");
      wait_ps("r5");
      step(1);
      enable = 1'b0;
      repeat (3) @(negedge clk);
      cmp("scoreboard_drained", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
